// File: rtl/jk_bank_arbiter_if.sv
// Request/grant/drive bundle between two requesters, the bank arbiter and
// the JK flip-flop bank it controls.
interface jk_bank_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int RPT_W = 4
);
  // requester A
  logic             req_a;
  logic [1:0]       cmd_a;
  logic [WIDTH-1:0] mask_a;
  logic [RPT_W-1:0] rpt_a;
  // requester B
  logic             req_b;
  logic [1:0]       cmd_b;
  logic [WIDTH-1:0] mask_b;
  logic [RPT_W-1:0] rpt_b;
  // arbiter status
  logic             gnt_a;
  logic             gnt_b;
  logic             done_a;
  logic             done_b;
  logic             busy;
  // bank drive
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;

  // requester / test side
  modport master (
    output req_a, cmd_a, mask_a, rpt_a,
    output req_b, cmd_b, mask_b, rpt_b,
    input  gnt_a, gnt_b, done_a, done_b, busy, J, K
  );

  // arbiter side
  modport slave (
    input  req_a, cmd_a, mask_a, rpt_a,
    input  req_b, cmd_b, mask_b, rpt_b,
    output gnt_a, gnt_b, done_a, done_b, busy, J, K
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one bank of WIDTH JK flip-flops
// between requesters A and B. A granted command is held on J/K for rpt+1
// cycles, then the owner receives a one-cycle done pulse. All outputs are
// registered; the J/K registers themselves hold the latched command.
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int RPT_W = 4
) (
  input  logic               clockPulse,
  input  logic               reset,
  jk_bank_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // J input for one bank bit set: every selected bit follows cmd[1]
  function automatic logic [WIDTH-1:0] j_bits(input logic [1:0] cmd,
                                              input logic [WIDTH-1:0] mask);
    j_bits = mask & {WIDTH{cmd[1]}};
  endfunction

  // K input for one bank bit set: every selected bit follows cmd[0]
  function automatic logic [WIDTH-1:0] k_bits(input logic [1:0] cmd,
                                              input logic [WIDTH-1:0] mask);
    k_bits = mask & {WIDTH{cmd[0]}};
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [RPT_W-1:0] cnt_r;
  logic [RPT_W-1:0] cnt_s;
  logic             owner_r;
  logic             owner_s;
  logic             last_grant_r;
  logic             last_grant_s;
  logic [WIDTH-1:0] j_r;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_r;
  logic [WIDTH-1:0] k_s;
  logic             gnt_a_r;
  logic             gnt_a_s;
  logic             gnt_b_r;
  logic             gnt_b_s;
  logic             done_a_r;
  logic             done_a_s;
  logic             done_b_r;
  logic             done_b_s;
  logic             busy_r;
  logic             busy_s;
  logic             pick_a_s;
  logic             pick_b_s;

  // Round-robin choice: A wins unless B is also requesting and A won last
  always_comb begin
    pick_a_s = 1'b0;
    pick_b_s = 1'b0;
    pick_a_s = bus.req_a & (~bus.req_b | (last_grant_r == SEL_B));
    pick_b_s = bus.req_b & ~pick_a_s;
  end

  // Next-state and next-output logic for the IDLE/APPLY sequencer
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    j_s          = j_r;
    k_s          = k_r;
    busy_s       = busy_r;
    gnt_a_s      = 1'b0;
    gnt_b_s      = 1'b0;
    done_a_s     = 1'b0;
    done_b_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        j_s    = {WIDTH{1'b0}};
        k_s    = {WIDTH{1'b0}};
        busy_s = 1'b0;
        if (pick_a_s) begin
          gnt_a_s      = 1'b1;
          last_grant_s = SEL_A;
          owner_s      = SEL_A;
          cnt_s        = bus.rpt_a;
          j_s          = j_bits(bus.cmd_a, bus.mask_a);
          k_s          = k_bits(bus.cmd_a, bus.mask_a);
          busy_s       = 1'b1;
          state_s      = ST_APPLY;
        end else if (pick_b_s) begin
          gnt_b_s      = 1'b1;
          last_grant_s = SEL_B;
          owner_s      = SEL_B;
          cnt_s        = bus.rpt_b;
          j_s          = j_bits(bus.cmd_b, bus.mask_b);
          k_s          = k_bits(bus.cmd_b, bus.mask_b);
          busy_s       = 1'b1;
          state_s      = ST_APPLY;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_APPLY: begin
        if (cnt_r != {RPT_W{1'b0}}) begin
          // pattern stays on J/K; only the remaining count moves
          cnt_s = cnt_r - RPT_W'(1);
        end else begin
          j_s     = {WIDTH{1'b0}};
          k_s     = {WIDTH{1'b0}};
          busy_s  = 1'b0;
          state_s = ST_IDLE;
          if (owner_r == SEL_A) begin
            done_a_s = 1'b1;
          end else begin
            done_b_s = 1'b1;
          end
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = {RPT_W{1'b0}};
        j_s     = {WIDTH{1'b0}};
        k_s     = {WIDTH{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset parks the bank drive at hold
  always_ff @(posedge clockPulse or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {RPT_W{1'b0}};
      owner_r      <= SEL_A;
      last_grant_r <= SEL_B;
      j_r          <= {WIDTH{1'b0}};
      k_r          <= {WIDTH{1'b0}};
      gnt_a_r      <= 1'b0;
      gnt_b_r      <= 1'b0;
      done_a_r     <= 1'b0;
      done_b_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      j_r          <= j_s;
      k_r          <= k_s;
      gnt_a_r      <= gnt_a_s;
      gnt_b_r      <= gnt_b_s;
      done_a_r     <= done_a_s;
      done_b_r     <= done_b_s;
      busy_r       <= busy_s;
    end
  end

  assign bus.gnt_a  = gnt_a_r;
  assign bus.gnt_b  = gnt_b_r;
  assign bus.done_a = done_a_r;
  assign bus.done_b = done_b_r;
  assign bus.busy   = busy_r;
  assign bus.J      = j_r;
  assign bus.K      = k_r;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: directed scenarios followed by
// random traffic from two requesters, checked every cycle against a
// transaction-level reference and a behavioural JK bank.
module tb_jk_bank_arbiter;
  localparam int WIDTH = 8;
  localparam int RPT_W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  jk_bank_arbiter_if #(.WIDTH(WIDTH), .RPT_W(RPT_W)) bus ();

  jk_bank_arbiter #(.WIDTH(WIDTH), .RPT_W(RPT_W)) dut (
    .clockPulse (clk),
    .reset      (reset),
    .bus        (bus.slave)
  );

  typedef struct packed {
    logic [1:0]       cmd;
    logic [WIDTH-1:0] mask;
    logic [RPT_W-1:0] rpt;
  } txn_t;

  txn_t todo_a[$], todo_b[$];   // scheduled, not yet presented
  txn_t exp_a[$],  exp_b[$];    // presented, awaiting grant
  bit   rand_mode = 1'b0;
  bit   end_req   = 1'b0;
  bit   end_done  = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] ref_q;
  logic             s_req_a, s_req_b;

  // behavioural JK bank driven by the arbiter
  always @(posedge clk or posedge reset) begin
    if (reset) bank_q <= '0;
    else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({bus.J[i], bus.K[i]})
          2'b01:   bank_q[i] <= 1'b0;
          2'b10:   bank_q[i] <= 1'b1;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end

  // requests as seen by the arbiter at each rising edge
  always @(posedge clk) begin
    s_req_a <= bus.req_a;
    s_req_b <= bus.req_b;
  end

  function automatic txn_t mk(input logic [1:0] c, input logic [WIDTH-1:0] m,
                              input logic [RPT_W-1:0] r);
    txn_t t;
    t.cmd = c; t.mask = m; t.rpt = r;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.cmd  = 2'($urandom_range(0, 3));
    t.mask = WIDTH'($urandom);
    t.rpt  = ($urandom_range(0, 5) == 0) ? RPT_W'($urandom_range(0, 15))
                                         : RPT_W'($urandom_range(0, 3));
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model / monitor ----------------
  bit               m_active;
  int               m_rem;
  bit               m_owner;
  bit               m_last;
  txn_t             m_cur;
  logic [WIDTH-1:0] m_j, m_k, e_j, e_k;
  logic [4:0]       e_ctl;      // {gnt_a, gnt_b, done_a, done_b, busy}
  int               win, has;
  bit               did_done;

  // compare every cycle; reset is checked 1 time unit after it rises
  always begin
    @(negedge clk or posedge reset);
    if (reset) begin
      #1;
      m_active = 1'b0; m_rem = 0; m_last = 1'b1; ref_q = '0;
      exp_a.delete(); exp_b.delete();
      check("reset_outputs",
            {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy, bus.J, bus.K}, 64'd0);
    end else begin
      e_ctl = 5'b0; e_j = '0; e_k = '0; did_done = 1'b0;
      if (m_active) begin
        if (m_rem > 0) begin
          m_rem--;
          e_ctl[0] = 1'b1; e_j = m_j; e_k = m_k;
        end else begin
          m_active = 1'b0;
          if (m_owner == 1'b0) e_ctl[2] = 1'b1; else e_ctl[1] = 1'b1;
          case (m_cur.cmd)
            2'b01:   ref_q = ref_q & ~m_cur.mask;
            2'b10:   ref_q = ref_q | m_cur.mask;
            2'b11:   if (m_cur.rpt[0] == 1'b0) ref_q = ref_q ^ m_cur.mask;  // odd toggle count
            default: ref_q = ref_q;
          endcase
          did_done = 1'b1;
        end
      end else begin
        win = -1;
        if (s_req_a && s_req_b) win = m_last ? 0 : 1;
        else if (s_req_a)       win = 0;
        else if (s_req_b)       win = 1;
        if (win >= 0) begin
          has = (win == 0) ? exp_a.size() : exp_b.size();
          check("txn_queued", 64'(has != 0), 64'd1);
          if (has != 0) begin
            if (win == 0) m_cur = exp_a.pop_front();
            else          m_cur = exp_b.pop_front();
            m_active = 1'b1; m_owner = win[0]; m_last = win[0];
            m_rem = int'(m_cur.rpt);
            m_j = m_cur.mask & {WIDTH{m_cur.cmd[1]}};
            m_k = m_cur.mask & {WIDTH{m_cur.cmd[0]}};
            if (win == 0) e_ctl[4] = 1'b1; else e_ctl[3] = 1'b1;
            e_ctl[0] = 1'b1; e_j = m_j; e_k = m_k;
          end
        end
      end
      check("outputs",
            {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy, bus.J, bus.K},
            {e_ctl, e_j, e_k});
      if (did_done) check("bank_q", bank_q, ref_q);
      if (end_req && !end_done) begin
        check("drain", 64'(exp_a.size() + exp_b.size() + int'(m_active)), 64'd0);
        end_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_cycle();
    txn_t t;
    bit   want;
    @(negedge clk);
    want = (todo_a.size() > 0) || (rand_mode && ($urandom_range(0, 3) == 0));
    if (bus.req_a && !bus.gnt_a) begin
      want = 1'b0;                       // still waiting: hold request and fields
    end else if (want) begin
      if (todo_a.size() > 0) t = todo_a.pop_front(); else t = rand_txn();
      bus.cmd_a = t.cmd; bus.mask_a = t.mask; bus.rpt_a = t.rpt; bus.req_a = 1'b1;
      exp_a.push_back(t);
    end else begin
      bus.req_a = 1'b0;
      t = rand_txn();                    // fields wander while not requesting
      bus.cmd_a = t.cmd; bus.mask_a = t.mask; bus.rpt_a = t.rpt;
    end
    want = (todo_b.size() > 0) || (rand_mode && ($urandom_range(0, 3) == 0));
    if (bus.req_b && !bus.gnt_b) begin
      want = 1'b0;
    end else if (want) begin
      if (todo_b.size() > 0) t = todo_b.pop_front(); else t = rand_txn();
      bus.cmd_b = t.cmd; bus.mask_b = t.mask; bus.rpt_b = t.rpt; bus.req_b = 1'b1;
      exp_b.push_back(t);
    end else begin
      bus.req_b = 1'b0;
      t = rand_txn();
      bus.cmd_b = t.cmd; bus.mask_b = t.mask; bus.rpt_b = t.rpt;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  initial begin
    bus.req_a = 1'b0; bus.cmd_a = 2'b00; bus.mask_a = '0; bus.rpt_a = '0;
    bus.req_b = 1'b0; bus.cmd_b = 2'b00; bus.mask_b = '0; bus.rpt_b = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // reset all bits, then set low nibble, then triple-toggle everything
    todo_a.push_back(mk(2'b01, 8'hFF, 4'd0));  run(6);
    todo_a.push_back(mk(2'b10, 8'h0F, 4'd0));  run(6);
    todo_b.push_back(mk(2'b11, 8'hFF, 4'd2));  run(8);

    // simultaneous, continuously held requests alternate A,B,A,B,A
    todo_a.push_back(mk(2'b10, 8'h11, 4'd1));
    todo_a.push_back(mk(2'b01, 8'h10, 4'd0));
    todo_a.push_back(mk(2'b11, 8'h0F, 4'd3));
    todo_b.push_back(mk(2'b11, 8'hC3, 4'd0));
    todo_b.push_back(mk(2'b10, 8'h80, 4'd2));
    run(40);

    // B arrives while A is applying a long command
    todo_a.push_back(mk(2'b11, 8'h3C, 4'd5));  run(2);
    todo_b.push_back(mk(2'b10, 8'h81, 4'd1));  run(16);

    // async reset in the middle of a toggle run with B pending
    todo_a.push_back(mk(2'b11, 8'hFF, 4'd7));  run(2);
    todo_b.push_back(mk(2'b10, 8'h0F, 4'd1));  run(3);
    @(posedge clk); #3;
    reset = 1'b1; bus.req_a = 1'b0; bus.req_b = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    todo_a.push_back(mk(2'b10, 8'hF0, 4'd0));
    todo_b.push_back(mk(2'b01, 8'hFF, 4'd0));
    run(10);

    // hold command at maximum repeat: 16 busy cycles, nothing driven
    todo_a.push_back(mk(2'b00, 8'hAA, 4'd15)); run(22);

    // random two-requester traffic, then let everything drain
    rand_mode = 1'b1; run(1500);
    rand_mode = 1'b0; run(60);

    end_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
